// File: rtl/exception_unit_pkg.sv
// Shared exception definitions: bus layout, one-hot cause codes and FSM state encodings.
// The coprocessor imports this package too, so these encodings must not change.
package exception_unit_pkg;

   localparam int EXC_BUS_W       = 70;
   localparam int EXC_OFF_BADADDR = 0;
   localparam int EXC_OFF_EPC     = 32;
   localparam int EXC_OFF_CAUSE   = 64;
   localparam int EXC_CAUSE_W     = 6;

   // Bit position inside the cause field follows {TR,OVF,RI,SYSCALL,ADDRS,ADDRL}
   localparam logic [EXC_CAUSE_W-1:0] CAUSE_ADDRL   = 6'b000001;
   localparam logic [EXC_CAUSE_W-1:0] CAUSE_ADDRS   = 6'b000010;
   localparam logic [EXC_CAUSE_W-1:0] CAUSE_SYSCALL = 6'b000100;
   localparam logic [EXC_CAUSE_W-1:0] CAUSE_RI      = 6'b001000;
   localparam logic [EXC_CAUSE_W-1:0] CAUSE_OVF     = 6'b010000;
   localparam logic [EXC_CAUSE_W-1:0] CAUSE_TR      = 6'b100000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_POST     = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_FLUSH    = 3'd3,
      ST_HALT     = 3'd4
   } exc_state_e;

   // Field order matches the exception_bus layout, so a record drives the bus directly
   typedef struct packed {
      logic [EXC_CAUSE_W-1:0] cause;
      logic [31:0]            epc;
      logic [31:0]            bad_addr;
   } exc_rec_t;

endpackage

// File: rtl/exception_unit_priority.sv
// Combinational arbiter: picks the oldest faulting stage, then the top cause inside it.
// Zero latency, no flow control; cand_vld is low when no valid stage raises a flag.
module exc_priority
   import exception_unit_pkg::*;
(
   input  logic        id_valid,
   input  logic        id_ri,
   input  logic        id_syscall,
   input  logic [31:0] id_pc,
   input  logic        ex_valid,
   input  logic        ex_ovf,
   input  logic        ex_tr,
   input  logic [31:0] ex_pc,
   input  logic        mem_valid,
   input  logic        mem_addrl,
   input  logic        mem_addrs,
   input  logic [31:0] mem_pc,
   input  logic [31:0] mem_addr,
   output logic        cand_vld,
   output exc_rec_t    cand
);

   logic mem_hit;
   logic ex_hit;
   logic id_hit;

   always_comb begin
      mem_hit  = mem_valid && (mem_addrl || mem_addrs);
      ex_hit   = ex_valid  && (ex_ovf    || ex_tr);
      id_hit   = id_valid  && (id_ri     || id_syscall);
      cand_vld = mem_hit || ex_hit || id_hit;
      cand     = '0;
      // Only MEM causes carry a data address; the others report zero
      if (mem_hit) begin
         cand.cause    = mem_addrl ? CAUSE_ADDRL : CAUSE_ADDRS;
         cand.epc      = mem_pc;
         cand.bad_addr = mem_addr;
      end else if (ex_hit) begin
         cand.cause = ex_ovf ? CAUSE_OVF : CAUSE_TR;
         cand.epc   = ex_pc;
      end else if (id_hit) begin
         cand.cause = id_ri ? CAUSE_RI : CAUSE_SYSCALL;
         cand.epc   = id_pc;
      end
   end

endmodule

// File: rtl/exception_unit.sv
// Exception controller: captures one exception, posts it, waits for coprocessor ack, then flushes.
// Bus valid one cycle after the fault is sampled; stall holds the pipeline until the flush ends.
module exception_unit
   import exception_unit_pkg::*;
#(
   parameter int FLUSH_CYCLES = 3,
   parameter int ACK_TIMEOUT  = 15
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 id_valid,
   input  logic                 id_ri,
   input  logic                 id_syscall,
   input  logic [31:0]          id_pc,
   input  logic                 ex_valid,
   input  logic                 ex_ovf,
   input  logic                 ex_tr,
   input  logic [31:0]          ex_pc,
   input  logic                 mem_valid,
   input  logic                 mem_addrl,
   input  logic                 mem_addrs,
   input  logic [31:0]          mem_pc,
   input  logic [31:0]          mem_addr,
   input  logic                 cop_ack,
   output logic [EXC_BUS_W-1:0] exception_bus,
   output logic                 flush_id,
   output logic                 flush_ex,
   output logic                 flush_mem,
   output logic                 stall,
   output logic                 panic
);

   exc_state_e state_q, state_d;
   exc_rec_t   cap_q, cap_d;
   logic [3:0] ack_cnt_q, ack_cnt_d;
   logic [3:0] flush_cnt_q, flush_cnt_d;
   logic       panic_q, panic_d;

   logic       cand_vld;
   exc_rec_t   cand;

   exc_priority u_priority (
      .id_valid   (id_valid),
      .id_ri      (id_ri),
      .id_syscall (id_syscall),
      .id_pc      (id_pc),
      .ex_valid   (ex_valid),
      .ex_ovf     (ex_ovf),
      .ex_tr      (ex_tr),
      .ex_pc      (ex_pc),
      .mem_valid  (mem_valid),
      .mem_addrl  (mem_addrl),
      .mem_addrs  (mem_addrs),
      .mem_pc     (mem_pc),
      .mem_addr   (mem_addr),
      .cand_vld   (cand_vld),
      .cand       (cand)
   );

   always_comb begin
      state_d     = state_q;
      cap_d       = cap_q;
      ack_cnt_d   = ack_cnt_q;
      flush_cnt_d = flush_cnt_q;
      panic_d     = panic_q;
      case (state_q)
         ST_IDLE: begin
            if (cand_vld) begin
               cap_d   = cand;
               state_d = ST_POST;
            end
         end
         ST_POST: begin
            ack_cnt_d = '0;
            state_d   = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // An ack on the last allowed cycle still wins over the timeout
            if (cop_ack) begin
               ack_cnt_d   = '0;
               flush_cnt_d = 4'(FLUSH_CYCLES - 1);
               state_d     = ST_FLUSH;
            end else begin
               ack_cnt_d = ack_cnt_q + 4'd1;
               if (ack_cnt_q + 4'd1 == 4'(ACK_TIMEOUT)) begin
                  panic_d = 1'b1;
                  state_d = ST_HALT;
               end
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      exception_bus = '0;
      if (state_q == ST_POST || state_q == ST_WAIT_ACK) begin
         exception_bus = cap_q;
      end
      flush_id  = (state_q == ST_FLUSH);
      flush_ex  = (state_q == ST_FLUSH);
      flush_mem = (state_q == ST_FLUSH);
      stall     = (state_q != ST_IDLE);
      panic     = panic_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cap_q       <= '0;
         ack_cnt_q   <= '0;
         flush_cnt_q <= '0;
         panic_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_q       <= cap_d;
         ack_cnt_q   <= ack_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         panic_q     <= panic_d;
      end
   end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against an age-based reference model.
module tb_exception_unit;

   localparam int FLUSH_CYCLES = 3;
   localparam int ACK_TIMEOUT  = 15;

   logic        clk;
   logic        reset;
   logic        id_valid, id_ri, id_syscall;
   logic [31:0] id_pc;
   logic        ex_valid, ex_ovf, ex_tr;
   logic [31:0] ex_pc;
   logic        mem_valid, mem_addrl, mem_addrs;
   logic [31:0] mem_pc, mem_addr;
   logic        cop_ack;
   logic [69:0] exception_bus;
   logic        flush_id, flush_ex, flush_mem, stall, panic;

   int n_checks = 0;
   int n_errors = 0;

   exception_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_valid      (id_valid),
      .id_ri         (id_ri),
      .id_syscall    (id_syscall),
      .id_pc         (id_pc),
      .ex_valid      (ex_valid),
      .ex_ovf        (ex_ovf),
      .ex_tr         (ex_tr),
      .ex_pc         (ex_pc),
      .mem_valid     (mem_valid),
      .mem_addrl     (mem_addrl),
      .mem_addrs     (mem_addrs),
      .mem_pc        (mem_pc),
      .mem_addr      (mem_addr),
      .cop_ack       (cop_ack),
      .exception_bus (exception_bus),
      .flush_id      (flush_id),
      .flush_ex      (flush_ex),
      .flush_mem     (flush_mem),
      .stall         (stall),
      .panic         (panic)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control outputs grouped as {panic, stall, flush_mem, flush_ex, flush_id}
   localparam logic [4:0] CTL_IDLE  = 5'b00000;
   localparam logic [4:0] CTL_BUSY  = 5'b01000;
   localparam logic [4:0] CTL_FLUSH = 5'b01111;
   localparam logic [4:0] CTL_HALT  = 5'b11000;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bus(input string nm, input logic [69:0] exp);
      n_checks++;
      if (exception_bus !== exp) begin
         n_errors++;
         $display("FAIL %s: exception_bus got %h expected %h", nm, exception_bus, exp);
      end
   endtask

   task automatic chk_ctl(input string nm, input logic [4:0] exp);
      logic [4:0] act;
      act = {panic, stall, flush_mem, flush_ex, flush_id};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: {panic,stall,flush_mem,flush_ex,flush_id} got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_ri = 0; id_syscall = 0; id_pc = 32'h0;
      ex_valid = 0; ex_ovf = 0; ex_tr = 0; ex_pc = 32'h0;
      mem_valid = 0; mem_addrl = 0; mem_addrs = 0; mem_pc = 32'h0; mem_addr = 32'h0;
      cop_ack = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   // ---------------- reference model ----------------
   // Returns {valid, cause[5:0], epc[31:0], bad[31:0]}; stages scanned oldest first.
   function automatic logic [70:0] ref_winner();
      logic        v[3];
      logic        hi[3];
      logic        lo[3];
      logic [31:0] pc[3];
      int          hi_bit[3];
      int          lo_bit[3];
      logic [70:0] r;
      v  = '{mem_valid, ex_valid, id_valid};
      hi = '{mem_addrl, ex_ovf, id_ri};
      lo = '{mem_addrs, ex_tr, id_syscall};
      pc = '{mem_pc, ex_pc, id_pc};
      hi_bit = '{0, 4, 3};
      lo_bit = '{1, 5, 2};
      r = '0;
      for (int s = 0; s < 3; s++) begin
         if (v[s] && (hi[s] || lo[s])) begin
            r[70]    = 1'b1;
            r[69:64] = 6'(1) << (hi[s] ? hi_bit[s] : lo_bit[s]);
            r[63:32] = pc[s];
            r[31:0]  = (s == 0) ? mem_addr : 32'h0;
            return r;
         end
      end
      return r;
   endfunction

   // Model state: busy flag, cycles since capture (0 = posting cycle), age when ack was seen
   bit          m_busy;
   int          m_age;
   int          m_ack_age;
   logic [69:0] m_rec;

   task automatic model_step();
      logic [70:0] w;
      if (!reset) begin
         m_busy = 0; m_age = 0; m_ack_age = -1;
      end else if (!m_busy) begin
         w = ref_winner();
         if (w[70]) begin
            m_busy = 1; m_age = 0; m_ack_age = -1; m_rec = w[69:0];
         end
      end else begin
         if (m_ack_age < 0 && m_age >= 1 && m_age <= ACK_TIMEOUT && cop_ack)
            m_ack_age = m_age;
         m_age++;
         if (m_ack_age >= 0 && m_age > m_ack_age + FLUSH_CYCLES)
            m_busy = 0;
      end
   endtask

   task automatic model_expect(output logic [69:0] eb, output logic [4:0] ec);
      eb = '0;
      ec = CTL_IDLE;
      if (m_busy) begin
         if (m_ack_age >= 0) begin
            ec = CTL_FLUSH;
         end else if (m_age <= ACK_TIMEOUT) begin
            eb = m_rec;
            ec = CTL_BUSY;
         end else begin
            ec = CTL_HALT;
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        idv, idri, idsc;
      logic        exv, exo, ext;
      logic        mv, ml, ms;
      logic [69:0] exp_bus;
   } vec_t;

   localparam logic [31:0] PC_ID  = 32'h0040_0000;
   localparam logic [31:0] PC_EX  = 32'h0040_0008;
   localparam logic [31:0] PC_MEM = 32'h0040_0010;
   localparam logic [31:0] DADDR  = 32'h0000_1003;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [8:0] f, input logic [69:0] e);
      vec_t v;
      {v.idv, v.idri, v.idsc, v.exv, v.exo, v.ext, v.mv, v.ml, v.ms} = f;
      v.exp_bus = e;
      return v;
   endfunction

   initial begin
      logic [69:0] eb;
      logic [4:0]  ec;
      int          mode;

      reset = 1'b0;
      clear_inputs();
      //                 idv ri sc exv ov tr  mv  l  s
      vecs[0]  = mk(9'b000_000_110, {6'b000001, PC_MEM, DADDR});
      vecs[1]  = mk(9'b101_110_000, {6'b010000, PC_EX, 32'h0});
      vecs[2]  = mk(9'b010_000_000, 70'h0);
      vecs[3]  = mk(9'b000_000_111, {6'b000001, PC_MEM, DADDR});
      vecs[4]  = mk(9'b000_101_101, {6'b000010, PC_MEM, DADDR});
      vecs[5]  = mk(9'b000_111_000, {6'b010000, PC_EX, 32'h0});
      vecs[6]  = mk(9'b000_101_000, {6'b100000, PC_EX, 32'h0});
      vecs[7]  = mk(9'b111_000_000, {6'b001000, PC_ID, 32'h0});
      vecs[8]  = mk(9'b101_000_000, {6'b000100, PC_ID, 32'h0});
      vecs[9]  = mk(9'b000_101_010, {6'b100000, PC_EX, 32'h0});
      vecs[10] = mk(9'b100_100_100, 70'h0);
      vecs[11] = mk(9'b101_010_001, {6'b000100, PC_ID, 32'h0});

      do_reset();
      chk_bus("reset_bus", 70'h0);
      chk_ctl("reset_ctl", CTL_IDLE);

      for (int i = 0; i < 12; i++) begin
         do_reset();
         {id_valid, id_ri, id_syscall} = {vecs[i].idv, vecs[i].idri, vecs[i].idsc};
         {ex_valid, ex_ovf, ex_tr}     = {vecs[i].exv, vecs[i].exo, vecs[i].ext};
         {mem_valid, mem_addrl, mem_addrs} = {vecs[i].mv, vecs[i].ml, vecs[i].ms};
         id_pc = PC_ID; ex_pc = PC_EX; mem_pc = PC_MEM; mem_addr = DADDR;
         tick();
         clear_inputs();
         chk_bus($sformatf("vec%0d_bus", i), vecs[i].exp_bus);
         chk_ctl($sformatf("vec%0d_ctl", i), (vecs[i].exp_bus != 70'h0) ? CTL_BUSY : CTL_IDLE);
      end

      // Ack in POST ignored; ack three cycles after POST gives exactly FLUSH_CYCLES of flush
      do_reset();
      mem_valid = 1; mem_addrl = 1; mem_pc = PC_MEM; mem_addr = DADDR;
      tick();
      clear_inputs();
      chk_bus("post_bus", {6'b000001, PC_MEM, DADDR});
      cop_ack = 1;
      tick();
      cop_ack = 0;
      chk_bus("ack_in_post_bus", {6'b000001, PC_MEM, DADDR});
      chk_ctl("ack_in_post_ctl", CTL_BUSY);
      tick();
      tick();
      chk_ctl("wait3_ctl", CTL_BUSY);
      cop_ack = 1;
      tick();
      cop_ack = 0;
      for (int i = 0; i < FLUSH_CYCLES; i++) begin
         chk_ctl($sformatf("flush%0d_ctl", i), CTL_FLUSH);
         chk_bus($sformatf("flush%0d_bus", i), 70'h0);
         tick();
      end
      chk_ctl("after_flush_ctl", CTL_IDLE);
      chk_bus("after_flush_bus", 70'h0);

      // Timeout: 15 WAIT_ACK cycles without ack, then sticky panic until reset
      do_reset();
      ex_valid = 1; ex_ovf = 1; ex_pc = PC_EX;
      tick();
      clear_inputs();
      for (int i = 1; i <= ACK_TIMEOUT; i++) begin
         tick();
         chk_ctl($sformatf("wait_age%0d_ctl", i), CTL_BUSY);
      end
      tick();
      chk_ctl("halt_ctl", CTL_HALT);
      chk_bus("halt_bus", 70'h0);
      id_valid = 1; id_ri = 1; cop_ack = 1;
      for (int i = 0; i < 3; i++) tick();
      chk_ctl("halt_sticky_ctl", CTL_HALT);
      chk_bus("halt_sticky_bus", 70'h0);
      do_reset();
      chk_ctl("halt_cleared_ctl", CTL_IDLE);

      // Reset during WAIT_ACK discards the exception with no flush pulse
      do_reset();
      mem_valid = 1; mem_addrs = 1; mem_pc = PC_MEM; mem_addr = DADDR;
      tick();
      clear_inputs();
      tick();
      chk_bus("pre_reset_wait_bus", {6'b000010, PC_MEM, DADDR});
      reset = 0; cop_ack = 1;
      tick();
      chk_ctl("midreset_ctl", CTL_IDLE);
      chk_bus("midreset_bus", 70'h0);
      reset = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_ctl($sformatf("post_midreset%0d_ctl", i), CTL_IDLE);
         cop_ack = 0;
      end

      // Randomized run against the reference model
      do_reset();
      m_busy = 0; m_age = 0; m_ack_age = -1; m_rec = '0;
      for (int c = 0; c < 3000; c++) begin
         mode = (c / 250) % 3;
         reset      = ($urandom_range(0, 199) != 0);
         id_valid   = 1'($urandom_range(0, 1));
         id_ri      = ($urandom_range(0, 9) == 0);
         id_syscall = ($urandom_range(0, 9) == 0);
         id_pc      = $urandom;
         ex_valid   = 1'($urandom_range(0, 1));
         ex_ovf     = ($urandom_range(0, 9) == 0);
         ex_tr      = ($urandom_range(0, 9) == 0);
         ex_pc      = $urandom;
         mem_valid  = 1'($urandom_range(0, 1));
         mem_addrl  = ($urandom_range(0, 9) == 0);
         mem_addrs  = ($urandom_range(0, 9) == 0);
         mem_pc     = $urandom;
         mem_addr   = $urandom;
         cop_ack    = (mode == 0) ? 1'b0 :
                      (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
         tick();
         model_step();
         model_expect(eb, ec);
         chk_bus("rand_bus", eb);
         chk_ctl("rand_ctl", ec);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3: cycles flush outputs stay asserted after acknowledge.
REQ-002 Parameter ACK_TIMEOUT, default 15: cycles to wait for coprocessor acknowledge before declaring panic.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
REQ-005 id_valid, id_ri, id_syscall  in  1 each  ID-stage instruction valid; reserved-instruction flag; syscall flag.
REQ-006 id_pc  in  32  ID-stage instruction PC.
REQ-007 ex_valid, ex_ovf, ex_tr  in  1 each  EX-stage instruction valid; overflow flag; trap flag.
REQ-008 ex_pc  in  32  EX-stage instruction PC.
REQ-009 mem_valid, mem_addrl, mem_addrs  in  1 each  MEM-stage instruction valid; load address error; store address error.
REQ-010 mem_pc, mem_addr  in  32 each  MEM-stage instruction PC; faulting data address.
REQ-011 cop_ack  in  1  coprocessor acknowledge (its cop_reset output).
REQ-012 exception_bus  out  70  [31:0] bad address, [63:32] EPC, [69:64] one-hot cause {TR,OVF,RI,SYSCALL,ADDRS,ADDRL} with ADDRL at bit 64.
REQ-013 flush_id, flush_ex, flush_mem  out  1 each  squash the named stage.
REQ-014 stall  out  1  freeze PC and pipeline registers.
REQ-015 panic  out  1  sticky: acknowledge timed out.

Function
REQ-016 FSM states: IDLE, POST, WAIT_ACK, FLUSH, HALT.
REQ-017 IDLE: a stage raises a candidate only while its valid bit is 1; the oldest candidate wins (MEM > EX > ID).
REQ-018 Within a stage, fixed priority: ADDRL > ADDRS, OVF > TR, RI > SYSCALL.
REQ-019 In IDLE, candidate present: winner latched into a capture register; next state POST.
REQ-020 Capture register holds: cause one-hot, EPC = winning stage PC, bad address = mem_addr for MEM causes, 0 otherwise.
REQ-021 exception_bus is driven from the capture register only in POST and WAIT_ACK; it is all-zero in every other state.
REQ-022 Latency: exception_bus is nonzero the cycle after the triggering inputs are sampled.
REQ-023 POST lasts exactly one cycle, then WAIT_ACK.
REQ-024 stall = 1 in POST, WAIT_ACK, FLUSH and HALT.
REQ-025 WAIT_ACK with cop_ack = 1: next state FLUSH, flush counter loaded with FLUSH_CYCLES-1.
REQ-026 WAIT_ACK: a 4-bit cycle counter increments each cycle without cop_ack.
REQ-027 When that counter reaches ACK_TIMEOUT: next state HALT, panic = 1.
REQ-028 FLUSH asserts all three flush outputs every cycle, decrementing the counter, and returns to IDLE on the cycle the counter equals 0 (exactly FLUSH_CYCLES cycles).
REQ-029 Inputs are ignored outside IDLE; no new exception is queued while one is in flight.
REQ-030 Simultaneous causes across stages: only the oldest stage is reported; younger ones are discarded, since they are flushed.
REQ-031 cop_ack arriving in POST is ignored; only WAIT_ACK samples it.
REQ-032 HALT is terminal until reset.

Reset
REQ-033 reset = 0 at posedge: state IDLE; capture register, counters and exception_bus zero; flush_* = 0; stall = 0; panic = 0.
REQ-034 reset mid-operation (any state) takes effect on that edge and discards the in-flight exception without emitting any flush.

Structure
REQ-035 Bus bit offsets (EXC_OFF_*), cause one-hot constants and FSM state encodings belong in the shared defines file, reused by the coprocessor.
REQ-036 One sub-module, exc_priority (combinational): takes stage flags, valids and PCs; returns the winning cause, EPC and bad address.

Verification
REQ-037 MEM addrl=1, mem_pc=0x400010, mem_addr=0x1003 -> next cycle bus[64]=1, [63:32]=0x400010, [31:0]=0x1003; stall=1.
REQ-038 Same cycle id_syscall and ex_ovf (ex_pc=0x400008) -> bus cause bit 68 (OVF) only, EPC=0x400008, bad address 0.
REQ-039 cop_ack 3 cycles after POST, FLUSH_CYCLES=3 -> flush_* high exactly 3 cycles, then IDLE; bus zero from the FLUSH entry.
REQ-040 No cop_ack -> panic=1 and stall stuck at 1 after ACK_TIMEOUT (15) WAIT_ACK cycles; only reset=0 clears them.
REQ-041 reset=0 during WAIT_ACK -> next cycle all outputs zero; no flush pulse.
REQ-042 id_ri=1 with id_valid=0 -> no exception; bus stays zero.
